// File: rtl/histo_acc_pingpong.sv
// Ping-pong per-bin histogram accumulator with frame total and drop count.
// Define HISTO_ACC_SAT_EN to clamp bin sums and frame total instead of wrapping.
module histo_acc_pingpong #(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 8,
    parameter int TOT_W  = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic [ADDR_W-1:0] iBin,
    input  logic [DATA_W-1:0] iValue,
    input  logic              iFrameEnd,
    input  logic [ADDR_W-1:0] iRdAddr,
    input  logic              iRdEn,
    output logic [DATA_W-1:0] oRdData,
    output logic              oRdValid,
    output logic              oBank,
    output logic              oBusy,
    output logic              oFrameDone,
    output logic [TOT_W-1:0]  oTotal,
    output logic [15:0]       oDropCnt
);

    localparam int BINS = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem0 [BINS];
    logic [DATA_W-1:0] mem1 [BINS];

    logic              act;
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_last;
    logic              rst_clr;
    logic              clr_we;
    logic              accept;
    logic              swap;
    logic              drop;

    logic              s0_v;
    logic [ADDR_W-1:0] s0_bin;
    logic [DATA_W-1:0] s0_val;
    logic              s0_tag;
    logic              s1_v;
    logic [ADDR_W-1:0] s1_bin;
    logic [DATA_W-1:0] s1_val;
    logic              s1_tag;
    logic [DATA_W-1:0] s1_rd;
    logic [DATA_W-1:0] s1_sum;
    logic [DATA_W-1:0] ram_rd;
    logic              fwd;

    logic [TOT_W-1:0]  run_tot;
    logic [TOT_W-1:0]  val_ext;
    logic [TOT_W-1:0]  tot_sum;
    logic [TOT_W-1:0]  tot_add;

    // Readout bank is always the one not being accumulated into
    assign act      = ~oBank;
    assign clr_last = &clr_ptr;
    assign val_ext  = TOT_W'(iValue);

    // FSM state register
    always_ff @(posedge iClk) begin
        if (iRst) state <= CLEAR;
        else      state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: if (clr_last)  state_nxt = RUN;
            RUN:   if (iFrameEnd) state_nxt = CLEAR;
        endcase
    end

    // FSM outputs and input qualification
    always_comb begin
        oBusy  = (state == CLEAR);
        clr_we = (state == CLEAR);
        accept = iValid && (state == RUN);
        swap   = iFrameEnd && (state == RUN);
        drop   = iValid && (state == CLEAR);
    end

    // Clear sweep pointer, bank select and frame-done pulse
    always_ff @(posedge iClk) begin
        if (iRst) begin
            clr_ptr    <= '0;
            rst_clr    <= 1'b1;
            oBank      <= 1'b1;
            oFrameDone <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            if (clr_we) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_last) begin
                    rst_clr    <= 1'b0;
                    oFrameDone <= ~rst_clr;
                end
            end
            if (swap) begin
                oBank   <= act;
                clr_ptr <= '0;
            end
        end
    end

`ifdef HISTO_ACC_SAT_EN
    logic [DATA_W:0] bin_wide;
    logic [TOT_W:0]  tot_wide;
    assign bin_wide = {1'b0, s1_rd} + {1'b0, s1_val};
    assign s1_sum   = bin_wide[DATA_W] ? {DATA_W{1'b1}} : bin_wide[DATA_W-1:0];
    assign tot_wide = {1'b0, run_tot} + {1'b0, val_ext};
    assign tot_sum  = tot_wide[TOT_W] ? {TOT_W{1'b1}} : tot_wide[TOT_W-1:0];
`else
    assign s1_sum  = s1_rd + s1_val;
    assign tot_sum = run_tot + val_ext;
`endif

    assign tot_add = accept ? tot_sum : run_tot;

    // S1 writes at the same edge S0 reads, so its sum must bypass the RAM
    assign fwd    = s1_v && s0_v && (s1_bin == s0_bin) && (s1_tag == s0_tag);
    assign ram_rd = s0_tag ? mem1[s0_bin] : mem0[s0_bin];

    // Pipeline valid bits
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
        end else begin
            s0_v <= accept;
            s1_v <= s0_v;
        end
    end

    // Pipeline payload, tagged with the bank active at acceptance
    always_ff @(posedge iClk) begin
        s0_bin <= iBin;
        s0_val <= iValue;
        s0_tag <= act;
        s1_bin <= s0_bin;
        s1_val <= s0_val;
        s1_tag <= s0_tag;
        s1_rd  <= fwd ? s1_sum : ram_rd;
    end

    // Bank 0 writes: sweep zeroes, then accumulate write-back
    always_ff @(posedge iClk) begin
        if (clr_we && (rst_clr || !act)) mem0[clr_ptr] <= '0;
        if (s1_v && !s1_tag)             mem0[s1_bin]  <= s1_sum;
    end

    // Bank 1 writes: sweep zeroes, then accumulate write-back
    always_ff @(posedge iClk) begin
        if (clr_we && (rst_clr || act)) mem1[clr_ptr] <= '0;
        if (s1_v && s1_tag)             mem1[s1_bin]  <= s1_sum;
    end

    // Running frame total, latched into oTotal at the swap
    always_ff @(posedge iClk) begin
        if (iRst) begin
            run_tot <= '0;
            oTotal  <= '0;
        end else if (swap) begin
            oTotal  <= tot_add;
            run_tot <= '0;
        end else begin
            run_tot <= tot_add;
        end
    end

    // Saturating count of samples refused while clearing
    always_ff @(posedge iClk) begin
        if (iRst)                           oDropCnt <= '0;
        else if (drop && oDropCnt != '1)    oDropCnt <= oDropCnt + 16'd1;
    end

    // Registered readout from the finished bank
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oRdData  <= '0;
            oRdValid <= 1'b0;
        end else begin
            oRdValid <= iRdEn;
            if (iRdEn) oRdData <= oBank ? mem1[iRdAddr] : mem0[iRdAddr];
        end
    end

endmodule

// File: tb/tb_histo_acc_pingpong.sv
// Self-checking bench for histo_acc_pingpong: directed scenarios plus
// randomized traffic against a transaction-level histogram model.
module tb_histo_acc_pingpong;

    localparam int DW   = 27;
    localparam int AW   = 8;
    localparam int TW   = 32;
    localparam int BINS = 256;
    localparam longint MAXD = (64'd1 << DW) - 1;
    localparam longint MAXT = (64'd1 << TW) - 1;

    logic          iClk = 0;
    logic          iRst = 0;
    logic          iValid = 0;
    logic [AW-1:0] iBin = 0;
    logic [DW-1:0] iValue = 0;
    logic          iFrameEnd = 0;
    logic [AW-1:0] iRdAddr = 0;
    logic          iRdEn = 0;
    logic [DW-1:0] oRdData;
    logic          oRdValid;
    logic          oBank;
    logic          oBusy;
    logic          oFrameDone;
    logic [TW-1:0] oTotal;
    logic [15:0]   oDropCnt;

    int tests = 0;
    int fails = 0;

    histo_acc_pingpong #(.DATA_W(DW), .ADDR_W(AW), .TOT_W(TW)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iBin(iBin),
        .iValue(iValue), .iFrameEnd(iFrameEnd), .iRdAddr(iRdAddr),
        .iRdEn(iRdEn), .oRdData(oRdData), .oRdValid(oRdValid),
        .oBank(oBank), .oBusy(oBusy), .oFrameDone(oFrameDone),
        .oTotal(oTotal), .oDropCnt(oDropCnt)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic longint add_bin(input longint a, input longint b);
        longint s = a + b;
`ifdef HISTO_ACC_SAT_EN
        if (s > MAXD) s = MAXD;
`else
        s = s & MAXD;
`endif
        return s;
    endfunction

    function automatic longint add_tot(input longint a, input longint b);
        longint s = a + b;
`ifdef HISTO_ACC_SAT_EN
        if (s > MAXT) s = MAXT;
`else
        s = s & MAXT;
`endif
        return s;
    endfunction

    // Model: histogram contents, clear progress, totals, counters
    longint mb [2][BINS];
    bit     model_on = 0;
    int     m_left = 0;
    int     m_ptr = 0;
    bit     m_rstclr = 0;
    bit     m_bank = 1;
    longint m_run = 0;
    longint m_total = 0;
    longint m_drop = 0;
    bit     m_fd = 0;
    bit     m_rdv = 0;
    longint m_rdd = 0;
    int     since_swap = 0;

    always begin
        @(posedge iClk);
        begin
            bit r, v, fe, re, act;
            int b, ra;
            longint val;
            r = iRst; v = iValid; fe = iFrameEnd; re = iRdEn;
            b = int'(iBin); ra = int'(iRdAddr); val = longint'(iValue);
            if (r) begin
                model_on = 1;
                m_left = BINS; m_ptr = 0; m_rstclr = 1; m_bank = 1;
                m_run = 0; m_total = 0; m_drop = 0; m_fd = 0;
                m_rdv = 0; m_rdd = 0; since_swap = 0;
            end else if (model_on) begin
                act = !m_bank;
                m_rdv = re;
                if (re) m_rdd = mb[m_bank][ra];
                m_fd = 0;
                if (since_swap < 1000) since_swap++;
                if (m_left > 0) begin
                    if (v && m_drop < 65535) m_drop++;
                    mb[act][m_ptr] = 0;
                    if (m_rstclr) mb[!act][m_ptr] = 0;
                    m_ptr++;
                    m_left--;
                    if (m_left == 0) begin
                        m_fd = !m_rstclr;
                        m_rstclr = 0;
                    end
                end else begin
                    if (v) begin
                        mb[act][b] = add_bin(mb[act][b], val);
                        m_run = add_tot(m_run, val);
                    end
                    if (fe) begin
                        m_total = m_run;
                        m_run = 0;
                        m_bank = act;
                        m_left = BINS;
                        m_ptr = 0;
                        since_swap = 0;
                    end
                end
            end
        end
        @(negedge iClk);
        if (model_on) begin
            chk("busy", oBusy, m_left > 0);
            chk("bank", oBank, m_bank);
            chk("fdone", oFrameDone, m_fd);
            chk("rdvalid", oRdValid, m_rdv);
            chk("rddata", oRdData, m_rdd);
            chk("total", oTotal, m_total);
            chk("drop", oDropCnt, m_drop);
        end
    end

    task automatic drive(input bit r, input bit v, input int b, input longint val,
                         input bit fe, input bit re, input int ra);
        @(negedge iClk);
        iRst = r; iValid = v; iBin = AW'(b); iValue = DW'(val);
        iFrameEnd = fe; iRdEn = re; iRdAddr = AW'(ra);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a, output longint d, output bit vld);
        drive(0, 0, 0, 0, 0, 1, a);
        idle();
        d = longint'(oRdData);
        vld = oRdValid;
    endtask

    task automatic wait_fd();
        int n = 0;
        while (!oFrameDone && n < 600) begin
            idle();
            n++;
        end
        chk("frame_done_wait", oFrameDone, 1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (oBusy && n < 1000) begin
            idle();
            n++;
        end
    endtask

    initial begin
        longint d;
        bit vld;
        bit pb;
        int n, nz;

        // Reset and initial sweep of both banks
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle();
        chk("rst_busy", oBusy, 1);
        chk("rst_bank", oBank, 1);
        chk("rst_total", oTotal, 0);
        chk("rst_drop", oDropCnt, 0);
        chk("rst_rdvalid", oRdValid, 0);
        count_busy(n);
        chk("rst_busy_cycles", n, 256);

        // Empty frame: every bin of the finished bank reads zero
        drive(0, 0, 0, 0, 1, 0, 0);
        wait_fd();
        nz = 0;
        for (int a = 0; a < BINS; a++) begin
            rd(a, d, vld);
            if (d != 0 || !vld) nz++;
        end
        chk("zero_bins", nz, 0);

        // Back-to-back hits on bin 5
        drive(0, 1, 5, 3, 0, 0, 0);
        drive(0, 1, 5, 4, 0, 0, 0);
        drive(0, 1, 5, 7, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        wait_fd();
        chk("b2b_total", oTotal, 14);
        drive(0, 0, 0, 0, 0, 1, 5);
        chk("b2b_rdvalid_early", oRdValid, 0);
        idle();
        chk("b2b_rdvalid", oRdValid, 1);
        chk("b2b_bin5", oRdData, 14);
        idle();
        chk("b2b_rdvalid_drop", oRdValid, 0);
        chk("b2b_hold", oRdData, 14);

        // Interleaved edge bins, frame end with the last sample
        pb = oBank;
        for (int i = 0; i < 10; i++)
            drive(0, 1, (i % 2 == 0) ? 0 : 255, 1, i == 9, 0, 0);
        wait_fd();
        chk("edge_bank_toggle", oBank, !pb);
        chk("edge_total", oTotal, 10);
        rd(0, d, vld);
        chk("edge_bin0", d, 5);
        rd(255, d, vld);
        chk("edge_bin255", d, 5);

        // Samples during the post-swap clear are dropped
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 9, 100, 0, 0, 0);
        drive(0, 1, 9, 100, 0, 0, 0);
        drive(0, 1, 9, 100, 0, 0, 0);
        idle();
        chk("drop_cnt", oDropCnt, 3);
        wait_fd();
        drive(0, 1, 9, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        wait_fd();
        rd(9, d, vld);
        chk("drop_excluded", d, 2);
        chk("drop_total", oTotal, 2);

        // Bin overflow
        drive(0, 1, 1, MAXD, 0, 0, 0);
        drive(0, 1, 1, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        wait_fd();
        rd(1, d, vld);
`ifdef HISTO_ACC_SAT_EN
        chk("ovf_bin1", d, MAXD);
`else
        chk("ovf_bin1", d, 1);
`endif
        chk("ovf_total", oTotal, MAXD + 2);

        // Reset in the middle of a frame
        drive(0, 1, 20, 50, 0, 0, 0);
        drive(0, 1, 20, 50, 0, 0, 0);
        drive(0, 1, 20, 50, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle();
        chk("mid_rst_busy", oBusy, 1);
        chk("mid_rst_bank", oBank, 1);
        chk("mid_rst_total", oTotal, 0);
        chk("mid_rst_drop", oDropCnt, 0);
        chk("mid_rst_rddata", oRdData, 0);
        chk("mid_rst_fdone", oFrameDone, 0);
        count_busy(n);
        chk("mid_rst_busy_cycles", n, 256);
        drive(0, 0, 0, 0, 1, 0, 0);
        wait_fd();
        rd(20, d, vld);
        chk("mid_rst_bin20", d, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit v, fe, re, r;
            int b, ra;
            longint val;
            r = (i == 1500);
            v = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0)
                val = MAXD - longint'($urandom_range(0, 50));
            else
                val = longint'($urandom_range(0, 1000));
            fe = ($urandom_range(0, 149) == 0);
            ra = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            re = (since_swap >= 3) && !m_rstclr && !r && ($urandom_range(0, 2) == 0);
            drive(r, v, b, val, fe, re, ra);
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/histo_acc_pingpong.md
Name: histo_acc_pingpong

Overview:
- Parametrised per-bin histogram accumulator with two internal RAM banks used ping-pong.
- Incoming (bin, value) samples are summed into the active bank via a 2-stage read-modify-write pipeline with same-bin forwarding.
- On frame end the banks swap; the finished bank becomes read-only for the downstream readout/VGA logic and the new active bank is hardware-cleared.
- Next generation of the camera area-histogram accumulator: generic depth/width, frame total, drop accounting.

Parameters:
- DATA_W, 27, bin counter and sample value width.
- ADDR_W, 8, bin index width; BINS = 2**ADDR_W.
- TOT_W, 32, width of the frame total register.

Ports:
- iClk  in  1  single clock, all logic posedge.
- iRst  in  1  synchronous reset, active-high.
- iValid  in  1  sample strobe.
- iBin  in  ADDR_W  bin index of sample.
- iValue  in  DATA_W  value added to bin.
- iFrameEnd  in  1  one-cycle pulse; swap banks.
- iRdAddr  in  ADDR_W  readout bin address (readout bank).
- iRdEn  in  1  readout request.
- oRdData  out  DATA_W  registered readout data.
- oRdValid  out  1  high one cycle after iRdEn.
- oBank  out  1  index of current readout bank.
- oBusy  out  1  high while in CLEAR.
- oFrameDone  out  1  one-cycle pulse when CLEAR finishes after a swap.
- oTotal  out  TOT_W  sum of all accepted values of last finished frame.
- oDropCnt  out  16  count of samples dropped while busy; saturates at 16'hFFFF.

Behaviour:
- Reset (sync, iRst=1 at posedge): state <= CLEAR, clear pointer <= 0, active bank = 0, oBank <= 1, oRdData <= 0, oRdValid <= 0, oFrameDone <= 0, oTotal <= 0, oDropCnt <= 0, pipeline valids <= 0, running total <= 0. Reset CLEAR zeroes both banks (BINS cycles); no oFrameDone pulse after reset clear.
- Reset mid-operation: aborts any sweep/pipeline, restarts the reset clear as above.
- FSM states: CLEAR, RUN.
  - CLEAR: write 0 at clear pointer each cycle, pointer +1; after writing BINS-1 -> RUN. oBusy=1.
  - RUN -> CLEAR on iFrameEnd.
- Accumulate pipeline (RUN only):
  - S0: iValid captured with bin, value and bank tag; RAM read issued.
  - S1: RAM data + value, written back to the tagged bank.
  - Forwarding: if S1 writes the same bin/bank that S0 is reading, S0 uses the S1 sum instead of RAM data. Back-to-back hits on one bin are exact.
  - Addition is modulo 2**DATA_W (see Optional Feature).
- Frame total: running total += iValue on every accepted sample, mod 2**TOT_W.
- iFrameEnd in RUN, same cycle as iValid: the sample is accepted into the ending frame. Next cycle:
  - active bank toggles; oBank <= old active bank;
  - oTotal <= final running total; running total <= 0;
  - CLEAR sweeps the new active bank.
  - In-flight S1 writes complete to their tagged (old) bank.
- oFrameDone pulses the cycle CLEAR->RUN after a swap.
- iValid while oBusy=1: sample dropped, oDropCnt +1 (saturating). iFrameEnd while oBusy=1: ignored.
- Readout: oRdData <= readout_bank[iRdAddr] one cycle after iRdEn; oRdValid mirrors iRdEn delayed 1. oRdData holds when iRdEn=0. Readout never conflicts with accumulate writes (different bank). Read spanning a swap returns the bank indicated by oBank at the request cycle.
- Bin wrap-around: iBin is always in range; no special case at BINS-1.

Optional Feature:
- Macro HISTO_ACC_SAT_EN.
- Defined: bin sums clamp at 2**DATA_W-1 and the frame total clamps at 2**TOT_W-1; forwarding path uses the clamped value.
- Undefined: both wrap modulo their width.

Test Plan:
- Reset, then wait BINS cycles -> oBusy falls after exactly 256 cycles, no oFrameDone; reading all bins after the first swap returns 0.
- Bin 5 gets 3,4,7 on consecutive cycles, then iFrameEnd -> after oFrameDone, read addr 5 gives 14, oRdValid 1 cycle after iRdEn, oTotal=14.
- Bins 0 and 255 each get value 1 on 10 interleaved cycles, iFrameEnd coincident with the last sample -> bin0=5, bin255=5, oTotal=10, oBank toggles.
- 3 samples with iValid during the post-swap CLEAR -> oDropCnt=3, and the next frame's bins exclude them.
- Bin 1 gets 2**27-1, then +2: without macro reads 1; with HISTO_ACC_SAT_EN reads 2**27-1.
- Assert iRst for 1 cycle mid-frame -> all outputs at reset values, oBusy high 256 cycles, prior bin contents read 0 after the next swap.
